// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: starts the multi-cycle multiply/divide unit, stalls the CPU while
// it runs, commits the result into HI/LO and reports divide-by-zero and timeout.
module hilo_ctrl #(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OpStart,
  input  logic        OpSel,
  input  logic        MoveHi,
  input  logic        MoveLo,
  input  logic [31:0] MoveData,
  output logic        MultStart,
  input  logic        MultFim,
  input  logic [31:0] MultHi,
  input  logic [31:0] MultLo,
  output logic        DivStart,
  input  logic        DivFim,
  input  logic        DivisaoPorZero,
  input  logic [31:0] DivHi,
  input  logic [31:0] DivLo,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Ocupado,
  output logic        Fim,
  output logic        ExcecaoDivZero,
  output logic        Erro
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t      state, state_next;
  logic        op_div, op_div_next;
  logic [CW-1:0] cycle_count, cycle_count_next;
  logic [31:0] hi_next, lo_next;
  logic        busy_next;
  logic        mult_start_next, div_start_next;
  logic        fim_next, div_zero_next, erro_next;

  logic        unit_fim;
  logic [31:0] unit_hi, unit_lo;

  assign unit_fim = op_div ? DivFim : MultFim;
  assign unit_hi  = op_div ? DivHi  : MultHi;
  assign unit_lo  = op_div ? DivLo  : MultLo;

  // Every output is registered from its next value, so nothing from the units
  // reaches the outputs combinationally.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      op_div         <= 1'b0;
      cycle_count    <= '0;
      Hi             <= '0;
      Lo             <= '0;
      Ocupado        <= 1'b0;
      MultStart      <= 1'b0;
      DivStart       <= 1'b0;
      Fim            <= 1'b0;
      ExcecaoDivZero <= 1'b0;
      Erro           <= 1'b0;
    end else begin
      state          <= state_next;
      op_div         <= op_div_next;
      cycle_count    <= cycle_count_next;
      Hi             <= hi_next;
      Lo             <= lo_next;
      Ocupado        <= busy_next;
      MultStart      <= mult_start_next;
      DivStart       <= div_start_next;
      Fim            <= fim_next;
      ExcecaoDivZero <= div_zero_next;
      Erro           <= erro_next;
    end
  end

  always_comb begin
    state_next       = state;
    op_div_next      = op_div;
    cycle_count_next = cycle_count;
    hi_next          = Hi;
    lo_next          = Lo;
    busy_next        = 1'b0;
    mult_start_next  = 1'b0;
    div_start_next   = 1'b0;
    fim_next         = 1'b0;
    div_zero_next    = 1'b0;
    erro_next        = 1'b0;

    case (state)
      IDLE: begin
        if (OpStart) begin
          op_div_next      = OpSel;
          cycle_count_next = '0;
          state_next       = RUN;
          busy_next        = 1'b1;
          mult_start_next  = ~OpSel;
          div_start_next   = OpSel;
        end else begin
          if (MoveHi) hi_next = MoveData;
          if (MoveLo) lo_next = MoveData;
        end
      end

      RUN: begin
        busy_next        = 1'b1;
        mult_start_next  = ~op_div;
        div_start_next   = op_div;
        cycle_count_next = cycle_count + CW'(1);
        if (unit_fim) begin
          state_next = DRAIN;
          fim_next   = 1'b1;
          if (op_div && DivisaoPorZero) begin
            div_zero_next = 1'b1;
          end else begin
            hi_next = unit_hi;
            lo_next = unit_lo;
          end
        end else if (cycle_count == CW'(TIMEOUT_CYCLES)) begin
          state_next = DRAIN;
          fim_next   = 1'b1;
          erro_next  = 1'b1;
        end
      end

      // Start and Ocupado were held high into this cycle by the RUN branch so the
      // unit sees Start through the cycle after its Fim; both drop on the next edge.
      DRAIN: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with behavioural negedge multiplier/divider stubs.
module tb_hilo_ctrl;

  localparam int TIMEOUT = 40;
  localparam int DIV_LAT = 33;
  localparam int MULT_LAT = 5;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        OpStart, OpSel, MoveHi, MoveLo;
  logic [31:0] MoveData;
  logic        MultStart, MultFim;
  logic [31:0] MultHi, MultLo;
  logic        DivStart, DivFim, DivisaoPorZero;
  logic [31:0] DivHi, DivLo;
  logic [31:0] Hi, Lo;
  logic        Ocupado, Fim, ExcecaoDivZero, Erro;

  logic signed [31:0] div_a, div_b;
  logic signed [63:0] mult_a, mult_b, product;
  logic        div_hang;
  int          div_cnt, mult_cnt;
  int          fim_pulses = 0;
  int          total = 0;
  int          passed = 0;
  int          failed = 0;
  int          n;

  hilo_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset), .OpStart(OpStart), .OpSel(OpSel),
    .MoveHi(MoveHi), .MoveLo(MoveLo), .MoveData(MoveData),
    .MultStart(MultStart), .MultFim(MultFim), .MultHi(MultHi), .MultLo(MultLo),
    .DivStart(DivStart), .DivFim(DivFim), .DivisaoPorZero(DivisaoPorZero),
    .DivHi(DivHi), .DivLo(DivLo), .Hi(Hi), .Lo(Lo), .Ocupado(Ocupado),
    .Fim(Fim), .ExcecaoDivZero(ExcecaoDivZero), .Erro(Erro)
  );

  always #5 Clk = ~Clk;

  assign product = mult_a * mult_b;

  // Divider stub: Fim rises DIV_LAT negedges after Start and holds until Start drops.
  always @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_cnt <= 0; DivFim <= 1'b0; DivisaoPorZero <= 1'b0; DivHi <= '0; DivLo <= '0;
    end else if (!DivStart) begin
      div_cnt <= 0; DivFim <= 1'b0; DivisaoPorZero <= 1'b0;
    end else if (div_cnt < DIV_LAT) begin
      div_cnt <= div_cnt + 1;
      if (div_cnt == DIV_LAT - 1 && !div_hang) begin
        DivFim <= 1'b1;
        DivisaoPorZero <= (div_b == 0);
        if (div_b == 0) begin
          DivHi <= 32'hDEAD_BEEF; DivLo <= 32'hBAD0_BAD0;
        end else begin
          DivHi <= div_a % div_b; DivLo <= div_a / div_b;
        end
      end
    end
  end

  always @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      mult_cnt <= 0; MultFim <= 1'b0; MultHi <= '0; MultLo <= '0;
    end else if (!MultStart) begin
      mult_cnt <= 0; MultFim <= 1'b0;
    end else if (mult_cnt < MULT_LAT) begin
      mult_cnt <= mult_cnt + 1;
      if (mult_cnt == MULT_LAT - 1) begin
        MultFim <= 1'b1; MultHi <= product[63:32]; MultLo <= product[31:0];
      end
    end
  end

  always @(posedge Clk) if (Fim) fim_pulses <= fim_pulses + 1;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic start_op(input logic sel);
    OpStart = 1'b1; OpSel = sel;
    tick();
    OpStart = 1'b0; MoveHi = 1'b0; MoveLo = 1'b0;
  endtask

  // Counts edges until Fim is seen; Ocupado must stay high the whole time.
  task automatic wait_fim(input int max_cycles, output int cycles);
    int busy_low;
    busy_low = 0;
    cycles = 0;
    do begin
      tick();
      cycles++;
      if (!Ocupado) busy_low++;
    end while (!Fim && cycles < max_cycles);
    check_output("fim_seen", 32'(Fim), 32'd1);
    check_output("busy_during_op", 32'(busy_low), 32'd0);
  endtask

  initial begin
    Reset = 1'b0; OpStart = 1'b0; OpSel = 1'b0; MoveHi = 1'b0; MoveLo = 1'b0;
    MoveData = '0; div_a = '0; div_b = 32'sd1; mult_a = '0; mult_b = '0; div_hang = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_output("reset_hi", Hi, 32'h0);
    check_output("reset_lo", Lo, 32'h0);
    check_output("reset_ctrl", {26'd0, Ocupado, Fim, ExcecaoDivZero, Erro, MultStart, DivStart}, 32'h0);
    Reset = 1'b1;
    tick();

    $display("[TB] div 100/7 with a concurrent MoveHi");
    div_a = 32'sd100; div_b = 32'sd7;
    MoveHi = 1'b1; MoveData = 32'h5A5A_5A5A;
    start_op(1'b1);
    check_output("div1_start", {29'd0, Ocupado, DivStart, MultStart}, 32'b110);
    wait_fim(60, n);
    check_output("div1_latency", 32'(n), 32'd33);
    check_output("div1_hi", Hi, 32'h0000_0002);
    check_output("div1_lo", Lo, 32'h0000_000E);
    check_output("div1_drain", {28'd0, Ocupado, DivStart, ExcecaoDivZero, Erro}, 32'b1100);
    tick();
    check_output("div1_idle", {29'd0, Ocupado, DivStart, Fim}, 32'b000);

    $display("[TB] div -100/7 then back-to-back mult 3 x -4");
    div_a = -32'sd100; div_b = 32'sd7;
    start_op(1'b1);
    wait_fim(60, n);
    check_output("div2_hi", Hi, 32'hFFFF_FFFE);
    check_output("div2_lo", Lo, 32'hFFFF_FFF2);
    mult_a = 64'sd3; mult_b = -64'sd4;
    OpStart = 1'b1; OpSel = 1'b0;
    tick();
    check_output("b2b_drain_edge", {29'd0, Ocupado, DivStart, Fim}, 32'b000);
    start_op(1'b0);
    check_output("mult_start", {29'd0, Ocupado, DivStart, MultStart}, 32'b101);
    MoveLo = 1'b1; MoveData = 32'h0000_1234;
    tick();
    MoveLo = 1'b0;
    wait_fim(20, n);
    check_output("mult_latency", 32'(n), 32'd4);
    check_output("mult_hi", Hi, 32'hFFFF_FFFF);
    check_output("mult_lo", Lo, 32'hFFFF_FFF4);
    tick();

    $display("[TB] mthi/mtlo then div 5/0");
    MoveHi = 1'b1; MoveData = 32'hAAAA_0000;
    tick();
    MoveHi = 1'b0; MoveLo = 1'b1; MoveData = 32'h0000_5555;
    tick();
    MoveLo = 1'b0;
    check_output("mthi", Hi, 32'hAAAA_0000);
    check_output("mtlo", Lo, 32'h0000_5555);
    div_a = 32'sd5; div_b = 32'sd0;
    start_op(1'b1);
    wait_fim(60, n);
    check_output("dz_latency", 32'(n), 32'd33);
    check_output("dz_flags", {30'd0, ExcecaoDivZero, Erro}, 32'b10);
    check_output("dz_hi", Hi, 32'hAAAA_0000);
    check_output("dz_lo", Lo, 32'h0000_5555);
    tick();
    check_output("dz_pulse_end", {29'd0, Ocupado, Fim, ExcecaoDivZero}, 32'b000);

    $display("[TB] divider that never finishes");
    div_hang = 1'b1; div_a = 32'sd9; div_b = 32'sd3;
    start_op(1'b1);
    wait_fim(60, n);
    check_output("to_latency", 32'(n), 32'(TIMEOUT + 1));
    check_output("to_flags", {30'd0, ExcecaoDivZero, Erro}, 32'b01);
    check_output("to_hi", Hi, 32'hAAAA_0000);
    check_output("to_lo", Lo, 32'h0000_5555);
    tick();
    check_output("to_idle", {28'd0, Ocupado, Fim, Erro, DivStart}, 32'b0000);
    div_hang = 1'b0;

    $display("[TB] reset ten cycles into a divide");
    div_a = 32'sd100; div_b = 32'sd7;
    start_op(1'b1);
    repeat (10) tick();
    #2;
    Reset = 1'b0;
    #1;
    check_output("rst_ctrl", {26'd0, Ocupado, Fim, ExcecaoDivZero, Erro, MultStart, DivStart}, 32'h0);
    check_output("rst_hi", Hi, 32'h0);
    check_output("rst_lo", Lo, 32'h0);
    repeat (2) tick();
    Reset = 1'b1;
    tick();
    start_op(1'b1);
    wait_fim(60, n);
    check_output("post_rst_latency", 32'(n), 32'd33);
    check_output("post_rst_hi", Hi, 32'h0000_0002);
    check_output("post_rst_lo", Lo, 32'h0000_000E);
    tick();
    check_output("fim_pulse_count", 32'(fim_pulses), 32'd6);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
